reel_spinner: RTL and testbench
===============================

REEL_SPINNER -- requirements
Module: reel_spinner

Interface
REQ-001 The block SHALL have parameter STEP_DIV, default 4: clocks per digit step, legal range 2..255.
REQ-002 The block SHALL have parameter DIGIT_MAX, default 9: highest digit value, legal range 1..15.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: spin request, normally the one-cycle timeout pulse of the upstream start-delay counter; level-sampled each clock.
REQ-006 The block SHALL have port stop_btn, input, 1 bit: player stop button, level; acted on only at its rising edge.
REQ-007 The block SHALL have port digit, output, 4 bits: current reel symbol, 0..DIGIT_MAX.
REQ-008 The block SHALL have port spinning, output, 1 bit: high in states SPIN and STOPPING.
REQ-009 The block SHALL have port stopped, output, 1 bit: high in state STOPPED.
REQ-010 The block SHALL have port chain_trigger, output, 1 bit: one-cycle pulse that starts the next reel's start-delay counter.

Function
REQ-011 The block SHALL implement an FSM with exactly the states IDLE, SPIN, STOPPING and STOPPED; all outputs SHALL be registered.
REQ-012 The block SHALL register stop_btn once into stop_q and define stop_edge = stop_btn & ~stop_q.
REQ-013 The block SHALL run a prescaler div (0..STEP_DIV-1) only in SPIN/STOPPING, incrementing each clock; tick = (div == STEP_DIV-1); div SHALL return to 0 after a tick.
REQ-014 On entry to SPIN from IDLE or STOPPED, the block SHALL clear div to 0, so the first digit step occurs STEP_DIV clocks after spinning rises.
REQ-015 In IDLE with start=1, the block SHALL move to SPIN; spinning and chain_trigger SHALL both be 1 in the next cycle.
REQ-016 chain_trigger SHALL be high for exactly one cycle per SPIN entry and 0 at all other times.
REQ-017 In SPIN, on each tick, digit SHALL increment by 1; DIGIT_MAX SHALL wrap to 0.
REQ-018 In SPIN with stop_edge=1, the block SHALL move to STOPPING; a tick in that same cycle SHALL still advance digit.
REQ-019 In STOPPING, the block SHALL keep stepping until the next tick; on that tick, digit SHALL advance once and the state SHALL become STOPPED on the same edge.
REQ-020 In STOPPED, digit SHALL hold and stop_edge SHALL be ignored.
REQ-021 In STOPPED with start=1, the block SHALL re-enter SPIN from the held digit (no digit clear) and pulse chain_trigger.
REQ-022 In SPIN and STOPPING, start SHALL be ignored.
REQ-023 In IDLE and STOPPED, stop_edge SHALL be ignored.
REQ-024 If start=1 and stop_edge=1 arrive in the same cycle in IDLE or STOPPED, start SHALL win and stop_edge SHALL be discarded.
REQ-025 If stop_btn is held high across SPIN entry, the block SHALL produce no stop; a release and re-press SHALL be required.
REQ-026 digit SHALL never exceed DIGIT_MAX.

Reset
REQ-027 While reset=1, the block SHALL immediately and asynchronously force state=IDLE, digit=0, div=0, stop_q=0, spinning=0, stopped=0 and chain_trigger=0.
REQ-028 Reset asserted mid-SPIN or mid-STOPPING SHALL abort the spin with no chain_trigger and no stopped pulse.
REQ-029 After reset deasserts, the block SHALL stay in IDLE until start=1.

Verification (STEP_DIV=4, DIGIT_MAX=9)
REQ-030 The bench SHALL check: reset, then start pulse at cycle 0 -> cycle 1 spinning=1 and chain_trigger=1; cycle 2 chain_trigger=0; digit=1 at cycle 5, digit=2 at cycle 9.
REQ-031 The bench SHALL check: spin 40 clocks from digit=0 -> digit steps 0..9 and returns to 0 at clock 40, never reaching 10.
REQ-032 The bench SHALL check: stop_btn rising one clock after digit becomes 3 -> digit=4 at the next tick, with stopped=1 and spinning=0 on the same edge; digit then holds 4 for 20 further clocks despite extra stop presses.
REQ-033 The bench SHALL check: stop_btn held high before start and kept high -> reel keeps spinning; release, then press -> stops at the following tick.
REQ-034 The bench SHALL check: reset asserted mid-cycle while digit=6 in SPIN -> digit=0 and all outputs 0 without waiting for a clock edge; state stays IDLE after release.
REQ-035 The bench SHALL check: in STOPPED at digit=4, start and stop_btn rise together -> SPIN, one chain_trigger pulse, digit=5 four clocks later, no stop.

Source files
------------

// File: rtl/reel_spinner.sv
// reel_spinner -- one reel of a slot-machine style digit spinner.
//
// A reel sits in IDLE until a start pulse arrives. It then spins, stepping
// its digit once every STEP_DIV clocks and wrapping DIGIT_MAX back to 0.
// A rising edge on the stop button arms the stop. The reel keeps stepping
// until the next step instant, advances once more, and then holds.
// Another start pulse restarts the reel from the held digit. Each entry into
// SPIN emits one chain_trigger pulse, which kicks the next reel's start-delay
// counter.
//
// Parameters:
//   STEP_DIV  - clocks per digit step, 2..255
//   DIGIT_MAX - highest digit value, 1..15
// Ports:
//   clock         in   single clock, rising edge
//   reset         in   asynchronous, active-high reset
//   start         in   spin request, level-sampled each clock
//   stop_btn      in   player stop button level, acted on at its rising edge
//   digit[3:0]    out  current reel symbol, 0..DIGIT_MAX
//   spinning      out  high in SPIN and STOPPING
//   stopped       out  high in STOPPED
//   chain_trigger out  one-cycle pulse on every entry into SPIN
module reel_spinner #(
  parameter int STEP_DIV  = 4,
  parameter int DIGIT_MAX = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       stop_btn,
  output logic [3:0] digit,
  output logic       spinning,
  output logic       stopped,
  output logic       chain_trigger
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SPIN     = 2'd1;
  localparam logic [1:0] ST_STOPPING = 2'd2;
  localparam logic [1:0] ST_STOPPED  = 2'd3;

  localparam logic [7:0] DIV_LAST   = 8'(STEP_DIV - 1);
  localparam logic [3:0] DIGIT_LAST = 4'(DIGIT_MAX);

  logic [1:0] state_q, state_d;
  logic [3:0] digit_q, digit_d;
  logic [7:0] div_q, div_d;
  logic       stop_q;
  logic       spinning_q, spinning_d;
  logic       stopped_q, stopped_d;
  logic       chain_q, chain_d;

  logic       stop_edge;
  logic       tick;
  logic [3:0] digit_step;
  logic [7:0] div_run;

  always_comb begin
    stop_edge = stop_btn & ~stop_q;
    tick      = (div_q == DIV_LAST);
    // Wrap at DIGIT_MAX. The >= comparison keeps the digit legal even if the
    // register ever holds an out-of-range value.
    digit_step = (digit_q >= DIGIT_LAST) ? 4'd0 : digit_q + 4'd1;
    div_run    = tick ? 8'd0 : div_q + 8'd1;

    state_d = state_q;
    digit_d = digit_q;
    div_d   = div_q;
    chain_d = 1'b0;

    case (state_q)
      // Start wins over any simultaneous stop edge. The edge is simply not
      // looked at here. Clearing div while parked means the first step lands
      // exactly STEP_DIV clocks after spinning rises.
      ST_IDLE, ST_STOPPED: begin
        div_d = 8'd0;
        if (start) begin
          state_d = ST_SPIN;
          chain_d = 1'b1;
        end
      end
      // A stop edge only arms the stop. A tick in the same cycle still steps.
      ST_SPIN: begin
        div_d = div_run;
        if (tick) begin
          digit_d = digit_step;
        end
        if (stop_edge) begin
          state_d = ST_STOPPING;
        end
      end
      // The reel lands on the digit reached at the next tick.
      ST_STOPPING: begin
        div_d = div_run;
        if (tick) begin
          digit_d = digit_step;
          state_d = ST_STOPPED;
        end
      end
      default: begin
        state_d = ST_IDLE;
        div_d   = 8'd0;
      end
    endcase

    // Status outputs are registered from the next state, so they line up
    // with state_q.
    spinning_d = (state_d == ST_SPIN) || (state_d == ST_STOPPING);
    stopped_d  = (state_d == ST_STOPPED);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      digit_q    <= 4'd0;
      div_q      <= 8'd0;
      stop_q     <= 1'b0;
      spinning_q <= 1'b0;
      stopped_q  <= 1'b0;
      chain_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      digit_q    <= digit_d;
      div_q      <= div_d;
      stop_q     <= stop_btn;
      spinning_q <= spinning_d;
      stopped_q  <= stopped_d;
      chain_q    <= chain_d;
    end
  end

  assign digit         = digit_q;
  assign spinning      = spinning_q;
  assign stopped       = stopped_q;
  assign chain_trigger = chain_q;

endmodule

// File: tb/tb_reel_spinner.sv
// Testbench for reel_spinner with STEP_DIV=4 and DIGIT_MAX=9.
// Directed scenarios pin literal values. A random phase then follows.
// Throughout the run, an elapsed-time reference model is compared against
// the DUT on every falling clock edge.
module tb_reel_spinner;
  localparam int SD = 4;
  localparam int DM = 9;

  logic       clock    = 1'b0;
  logic       reset    = 1'b0;
  logic       start    = 1'b0;
  logic       stop_btn = 1'b0;
  logic [3:0] digit;
  logic       spinning;
  logic       stopped;
  logic       chain_trigger;

  int n_vec  = 0;
  int n_err  = 0;
  bit chk_en = 1'b0;

  reel_spinner #(.STEP_DIV(SD), .DIGIT_MAX(DM)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .stop_btn      (stop_btn),
    .digit         (digit),
    .spinning      (spinning),
    .stopped       (stopped),
    .chain_trigger (chain_trigger)
  );

  always #5 clock = ~clock;

  // Reference model. While the reel is active, the digit is
  // base + (clocks since entry)/SD, taken modulo DM+1.
  bit m_active   = 1'b0;
  bit m_stopped  = 1'b0;
  bit m_chain    = 1'b0;
  bit m_stop_req = 1'b0;
  bit m_prev_btn = 1'b0;
  int m_base     = 0;
  int m_n        = 0;
  int m_held     = 0;

  function automatic int m_digit();
    if (m_active) return (m_base + m_n / SD) % (DM + 1);
    return m_held;
  endfunction

  always @(posedge clock or posedge reset) begin : model
    bit pressed;
    bit at_step;
    if (reset) begin
      m_active   <= 1'b0;
      m_stopped  <= 1'b0;
      m_chain    <= 1'b0;
      m_stop_req <= 1'b0;
      m_prev_btn <= 1'b0;
      m_base     <= 0;
      m_n        <= 0;
      m_held     <= 0;
    end else begin
      pressed    = stop_btn && !m_prev_btn;
      m_prev_btn <= stop_btn;
      m_chain    <= 1'b0;
      if (!m_active) begin
        if (start) begin
          m_active   <= 1'b1;
          m_stopped  <= 1'b0;
          m_chain    <= 1'b1;
          m_base     <= m_held;
          m_n        <= 0;
          m_stop_req <= 1'b0;
        end
      end else begin
        at_step = (m_n % SD) == (SD - 1);
        m_n <= m_n + 1;
        if (at_step && m_stop_req) begin
          m_active  <= 1'b0;
          m_stopped <= 1'b1;
          m_held    <= (m_base + (m_n + 1) / SD) % (DM + 1);
        end else if (pressed) begin
          m_stop_req <= 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("model_digit", int'(digit), m_digit());
      check("model_spinning", int'(spinning), int'(m_active));
      check("model_stopped", int'(stopped), int'(m_stopped));
      check("model_chain", int'(chain_trigger), int'(m_chain));
      check("digit_range", int'(digit <= 4'(DM)), 1);
    end
  end

  // Advance n rising edges, then settle 2 time units past the last one.
  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #2;
  endtask

  initial begin
    int  maxd;
    bit  found;

    // Reset state
    #1 reset = 1'b1;
    #1;
    check("reset_digit", int'(digit), 0);
    check("reset_spinning", int'(spinning), 0);
    check("reset_stopped", int'(stopped), 0);
    check("reset_chain", int'(chain_trigger), 0);
    chk_en = 1'b1;
    step(2);
    reset = 1'b0;
    step(3);
    check("idle_after_reset_spinning", int'(spinning), 0);
    check("idle_after_reset_digit", int'(digit), 0);
    $display("scenario reset/idle done, t=%0t", $time);

    // Start pulse and first-step latency
    start = 1'b1;
    step();
    start = 1'b0;
    check("c1_spinning", int'(spinning), 1);
    check("c1_chain", int'(chain_trigger), 1);
    check("c1_digit", int'(digit), 0);
    step();
    check("c2_chain", int'(chain_trigger), 0);
    step(3);
    check("c5_digit", int'(digit), 1);
    step(4);
    check("c9_digit", int'(digit), 2);
    $display("scenario start latency done, digit=%0d", digit);

    // Full wrap over 40 clocks
    maxd = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (int'(digit) > maxd) maxd = int'(digit);
    end
    check("wrap_c41_digit", int'(digit), 0);
    check("wrap_max_digit", maxd, DM);
    $display("scenario wrap done, max digit=%0d", maxd);

    // Stop one clock after digit becomes 3
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (digit == 4'd3) found = 1'b1;
      else step();
    end
    check("wait_digit3", int'(found), 1);
    step();
    stop_btn = 1'b1;
    step(2);
    check("stop_pre_tick_digit", int'(digit), 3);
    check("stop_pre_tick_spinning", int'(spinning), 1);
    step();
    check("stop_digit", int'(digit), 4);
    check("stop_stopped", int'(stopped), 1);
    check("stop_spinning", int'(spinning), 0);
    for (int i = 0; i < 20; i++) begin
      stop_btn = (i % 3 == 0) ? 1'b0 : 1'b1;
      step();
      check("stop_hold_digit", int'(digit), 4);
    end
    stop_btn = 1'b0;
    step();
    $display("scenario stop at 4 done, digit=%0d", digit);

    // Restart from STOPPED with start and stop rising together
    start    = 1'b1;
    stop_btn = 1'b1;
    step();
    start = 1'b0;
    check("restart_spinning", int'(spinning), 1);
    check("restart_chain", int'(chain_trigger), 1);
    check("restart_digit", int'(digit), 4);
    check("restart_stopped", int'(stopped), 0);
    step(4);
    check("restart_c5_digit", int'(digit), 5);
    step(12);
    check("restart_held_btn_spinning", int'(spinning), 1);
    stop_btn = 1'b0;
    $display("scenario restart done, digit=%0d", digit);

    // Asynchronous reset mid-cycle at digit 6
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (digit == 4'd6) found = 1'b1;
      else step();
    end
    check("wait_digit6", int'(found), 1);
    #1 reset = 1'b1;
    #1;
    check("async_rst_digit", int'(digit), 0);
    check("async_rst_spinning", int'(spinning), 0);
    check("async_rst_stopped", int'(stopped), 0);
    check("async_rst_chain", int'(chain_trigger), 0);
    step(2);
    reset = 1'b0;
    step(5);
    check("post_rst_spinning", int'(spinning), 0);
    check("post_rst_digit", int'(digit), 0);
    $display("scenario async reset done");

    // Stop held high across spin entry; release and re-press stops the reel
    stop_btn = 1'b1;
    step(2);
    start = 1'b1;
    step();
    start = 1'b0;
    check("held_entry_chain", int'(chain_trigger), 1);
    step(30);
    check("held_c31_spinning", int'(spinning), 1);
    check("held_c31_stopped", int'(stopped), 0);
    stop_btn = 1'b0;
    step();
    stop_btn = 1'b1;
    step();
    check("repress_c33_digit", int'(digit), 8);
    check("repress_c33_spinning", int'(spinning), 1);
    step(3);
    check("repress_c36_spinning", int'(spinning), 1);
    step();
    check("repress_c37_digit", int'(digit), 9);
    check("repress_c37_stopped", int'(stopped), 1);
    stop_btn = 1'b0;
    $display("scenario held button done, digit=%0d", digit);

    // Random phase
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) stop_btn = ~stop_btn;
      if ($urandom_range(0, 599) == 0) begin
        reset = 1'b1;
        step(1 + $urandom_range(0, 2));
        reset = 1'b0;
      end
      step();
    end
    start    = 1'b0;
    stop_btn = 1'b0;
    step(2);
    $display("scenario random done");

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
